// File: rtl/load_store_unit.sv
// Load/store initiator for the data-memory port: one request at a time, address
// range check, single-cycle memory access and a held response until accepted.
module load_store_unit #(
  parameter int unsigned ADDR_W = 6,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OFF_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [DATA_W-1:0] req_base,
  input  logic [OFF_W-1:0]  req_offset,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] d_mem_addr,
  output logic              d_mem_we,
  output logic [DATA_W-1:0] d_mem_data_in,
  input  logic [DATA_W-1:0] d_mem_data_out
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e              r_state, w_state_n;
  logic                r_store, w_store_n;
  logic [ADDR_W-1:0]   r_addr, w_addr_n;
  logic [DATA_W-1:0]   r_wdata, w_wdata_n;
  logic [DATA_W-1:0]   r_rsp_data, w_rsp_data_n;
  logic                r_rsp_err, w_rsp_err_n;

  logic [DATA_W-1:0]   w_ea;
  logic                w_in_range;

  assign w_ea       = req_base + {{(DATA_W-OFF_W){req_offset[OFF_W-1]}}, req_offset};
  assign w_in_range = ~|w_ea[DATA_W-1:ADDR_W];

  always_comb begin
    w_state_n    = r_state;
    w_store_n    = r_store;
    w_addr_n     = r_addr;
    w_wdata_n    = r_wdata;
    w_rsp_data_n = r_rsp_data;
    w_rsp_err_n  = r_rsp_err;
    unique case (r_state)
      StIdle: begin
        if (req_valid) begin
          w_store_n = req_store;
          w_addr_n  = w_ea[ADDR_W-1:0];
          w_wdata_n = req_wdata;
          if (w_in_range) begin
            w_state_n = StAccess;
          end else begin
            // Out of range: skip the memory entirely and report straight away.
            w_state_n    = StResp;
            w_rsp_err_n  = 1'b1;
            w_rsp_data_n = '0;
          end
        end
      end
      StAccess: begin
        w_state_n    = StResp;
        w_rsp_err_n  = 1'b0;
        w_rsp_data_n = r_store ? '0 : d_mem_data_out;
      end
      StResp: begin
        if (rsp_ready) w_state_n = StIdle;
      end
      default: w_state_n = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= StIdle;
      r_store    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rsp_data <= '0;
      r_rsp_err  <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_store    <= w_store_n;
      r_addr     <= w_addr_n;
      r_wdata    <= w_wdata_n;
      r_rsp_data <= w_rsp_data_n;
      r_rsp_err  <= w_rsp_err_n;
    end
  end

  // Write enable is pure state decode so an asynchronous reset kills it at once.
  assign req_ready     = (r_state == StIdle);
  assign rsp_valid     = (r_state == StResp);
  assign d_mem_we      = (r_state == StAccess) && r_store;
  assign d_mem_addr    = r_addr;
  assign d_mem_data_in = r_wdata;
  assign rsp_data      = r_rsp_data;
  assign rsp_err       = r_rsp_err;

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator side of the processor's data-memory interface. Accepts one load or store request at a time from the execute stage over a valid/ready handshake. Computes the effective address as base plus sign-extended offset, range-checks it and drives the data memory's address, write-enable and write-data pins. The memory has a combinational read port and a synchronous write port. The unit then returns load data, or a store completion, over a valid/ready response handshake.

Parameters:
ADDR_W, 6, data-memory address width (memory depth 2^ADDR_W words)
DATA_W, 64, data word width
OFF_W, 16, signed immediate offset width

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_store  input  1  1 = store, 0 = load
req_base  input  DATA_W  base register value
req_offset  input  OFF_W  signed offset
req_wdata  input  DATA_W  store data
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_data  output  DATA_W  load data; 0 for stores and errors
rsp_err  output  1  effective address out of range, no access made
d_mem_addr  output  ADDR_W  memory address
d_mem_we  output  1  memory write enable
d_mem_data_in  output  DATA_W  memory write data
d_mem_data_out  input  DATA_W  memory read data (combinational from d_mem_addr)

Behaviour:
- One clock domain: clk. Reset is asynchronous and active-high: rst.
- FSM states are IDLE, ACCESS, RESP. Reset state is IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_data=0, rsp_err=0, d_mem_addr=0, d_mem_we=0, d_mem_data_in=0.
- req_ready=1 only in IDLE. rsp_valid=1 only in RESP. All outputs are driven from registers or state decode, with no combinational path from the request inputs.
- Effective address: EA = req_base + sign_extend(req_offset) to DATA_W, computed modulo 2^DATA_W. Sign extension is mandatory, so offset 16'hFFFF means -1.
- EA is in range iff EA[DATA_W-1:ADDR_W] == 0.
- IDLE, on a cycle with req_valid && req_ready:
  - Register op, EA[ADDR_W-1:0] into d_mem_addr, and req_wdata into d_mem_data_in.
  - If in range, go to ACCESS. Otherwise go to RESP with rsp_err=1 and rsp_data=0, and make no memory access.
- ACCESS lasts exactly one cycle.
  - Store: d_mem_we=1 for this cycle only, so the memory writes at the closing edge. Then rsp_data=0 and rsp_err=0.
  - Load: d_mem_we=0. Capture d_mem_data_out into rsp_data at the closing edge; rsp_err=0.
  - Go to RESP.
- RESP: hold rsp_valid, rsp_data and rsp_err stable until rsp_valid && rsp_ready, then go to IDLE.
  - req_ready returns to 1 in the cycle after the handshake; there is no request/response overlap.
- Latency:
  - In range: request accepted at edge N, ACCESS during cycle N..N+1, rsp_valid high from edge N+1.
  - Error: rsp_valid high from the edge after acceptance.
  - With rsp_ready held high, a new request can be accepted every 3 cycles.
- d_mem_addr and d_mem_data_in hold their last values outside ACCESS. d_mem_we is never 1 outside ACCESS.
- Requests presented while req_ready=0 are ignored; the requester must hold them.
- Reset mid-operation: asynchronous return to IDLE with reset values. d_mem_we drops immediately, so a store interrupted in ACCESS does not write, and any pending response is discarded.
- Store then load to the same address returns the stored value, because the write commits at the end of ACCESS before the next request is accepted.

Test Plan:
- Bench memory model preloaded with mem[1]=10 and mem[2]=30. Load base=0, offset=1 -> rsp_valid 2 edges after acceptance, rsp_data=10, rsp_err=0, d_mem_we never 1.
- Store base=2, offset=3, wdata=64'h8000_0000_0000_0000 -> d_mem_we=1 for exactly 1 cycle with d_mem_addr=5. A following load of address 5 returns 64'h8000_0000_0000_0000.
- Load base=64, offset=16'hFFFF (-1) -> address 63, rsp_err=0.
- Load base=63, offset=1 -> rsp_err=1, rsp_data=0, no ACCESS cycle, d_mem_we=0.
- Backpressure: hold rsp_ready=0 for 5 cycles after a load of mem[2] -> rsp_valid and rsp_data=30 stable throughout, req_ready=0. req_valid pulses during this time are ignored.
- Assert rst during the ACCESS cycle of a store to address 7 -> d_mem_we drops immediately, mem[7] unchanged, outputs at reset values, req_ready=1 after reset release.
